// File: rtl/team_06_i2s_pkg.sv
// Shared types and default parameter values for the multi-channel I2S receiver.
package team_06_i2s_pkg;

  localparam int unsigned DefDataW     = 16;
  localparam int unsigned DefNumCh     = 2;
  localparam int unsigned DefClkDiv    = 8;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/team_06_sample_fifo.sv
// First-word fall-through sample FIFO; a push into a full FIFO without a pop is dropped.
module team_06_sample_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             drop
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [PtrW:0]    cnt_q;
  logic             empty, full, pop, do_push;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (PtrW + 1)'(DEPTH));
    pop     = !empty && ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
    valid   = !empty;
    rdata   = empty ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (pop)     rd_q <= rd_q + PtrW'(1);
      if (do_push && !pop)      cnt_q <= cnt_q + (PtrW + 1)'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/team_06_i2s_rx_multi.sv
// I2S master receiver: generates sck/ws, deserialises ADC slots and queues samples in a FIFO.
module team_06_i2s_rx_multi
  import team_06_i2s_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adc_serial_in,
  output logic              sck,
  output logic              ws,
  output logic [DATA_W-1:0] sample_out,
  output logic              ch_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              sck_q, sck_d, ws_q, ws_d, ovf_q, ovf_d;
  logic              run, wrap, push, drop;
  logic [DATA_W:0]   push_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en)  state_d = StRun;
      StRun:  if (!en) state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    push      = 1'b0;
    push_data = {ws_q, shift_q, adc_serial_in};
    run       = (state_q == StRun) && en;
    wrap      = (div_q == DivW'(CLK_DIV - 1));
    if (!run) begin
      div_d   = '0;
      cnt_d   = '0;
      shift_d = '0;
      sck_d   = 1'b0;
      ws_d    = 1'b0;
    end else begin
      div_d = wrap ? '0 : div_q + DivW'(1);
      if (wrap) begin
        sck_d = !sck_q;
        if (!sck_q) begin
          // Rise event: bit 0 is the I2S delay bit and is not captured.
          if (cnt_q != '0) shift_d = {shift_q[DATA_W-3:0], adc_serial_in};
          if (cnt_q == CntW'(DATA_W)) begin
            cnt_d = '0;
            push  = (NUM_CH == 2) || !ws_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (cnt_q == '0) begin
          // Counter only sits at 0 on a fall right after the last bit of a slot.
          ws_d = !ws_q;
        end
      end
    end
    ovf_d = (ovf_q && !clear_ovf) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      ovf_q   <= ovf_d;
    end
  end

  team_06_sample_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .ready (sample_ready),
    .valid (sample_valid),
    .rdata ({ch_out, sample_out}),
    .drop  (drop)
  );

  assign sck      = sck_q;
  assign ws       = ws_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_team_06_i2s_rx_multi.sv
// Bench: an I2S transmitter model drives the receivers; queue models predict FIFO contents.
module tb_team_06_i2s_rx_multi;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, adc, rdy0, rdy1, clr;
  logic sck0, ws0, ch0, v0, ovf0;
  logic sck1, ws1, ch1, v1, ovf1;
  logic [DW-1:0] so0, so1;

  team_06_i2s_rx_multi #(.DATA_W(DW), .NUM_CH(2), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut0 (
    .clk(clk), .rst(rst), .en(en), .adc_serial_in(adc), .sck(sck0), .ws(ws0),
    .sample_out(so0), .ch_out(ch0), .sample_valid(v0), .sample_ready(rdy0),
    .overflow(ovf0), .clear_ovf(clr)
  );

  team_06_i2s_rx_multi #(.DATA_W(DW), .NUM_CH(1), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut1 (
    .clk(clk), .rst(rst), .en(en), .adc_serial_in(adc), .sck(sck1), .ws(ws1),
    .sample_out(so1), .ch_out(ch1), .sample_valid(v1), .sample_ready(rdy1),
    .overflow(ovf1), .clear_ovf(clr)
  );

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
  } smp_t;

  typedef struct {
    string name;
    logic  en;
    logic  rdy;
    logic  clr;
    int    cycles;
    logic  exp_valid;
    logic  exp_ovf;
  } vec_t;

  smp_t          q0[$], q1[$];
  logic [DW-1:0] words_q[$];
  logic          m_ovf0, m_ovf1, active, cur_ch, psck, pws;
  logic [DW-1:0] word;
  int            idx, cyc, last_rise, last_tog;
  int            checks, failures;
  vec_t          vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] next_word();
    if (words_q.size() != 0) return words_q.pop_front();
    return DW'($urandom);
  endfunction

  // Transmitter side of I2S: data changes on sck falls, a ws change starts a new slot.
  task automatic step(input int n);
    logic a_rst, a_en, a_r0, a_r1, a_clr, rise, fall, d0, d1;
    for (int k = 0; k < n; k++) begin
      a_rst = rst; a_en = en; a_r0 = rdy0; a_r1 = rdy1; a_clr = clr;
      @(posedge clk);
      #1;
      cyc++;
      d0 = 1'b0;
      d1 = 1'b0;
      if (a_rst) begin
        q0.delete(); q1.delete();
        m_ovf0 = 1'b0; m_ovf1 = 1'b0;
        active = 1'b0; idx = 0; last_rise = -1; last_tog = -1;
      end else begin
        if (q0.size() != 0 && a_r0) void'(q0.pop_front());
        if (q1.size() != 0 && a_r1) void'(q1.pop_front());
        if (!a_en) begin
          active = 1'b0; idx = 0; last_rise = -1; last_tog = -1;
          chk("idle_sck", sck0, 0);
          chk("idle_ws", ws0, 0);
        end else if (!active) begin
          active = 1'b1; idx = 0; cur_ch = 1'b0; word = next_word();
        end else begin
          rise = sck0 && !psck;
          fall = !sck0 && psck;
          if (ws0 != pws) chk("ws_on_fall", fall, 1);
          if (rise) begin
            if (last_rise >= 0) chk("sck_period", cyc - last_rise, 2 * CD);
            last_rise = cyc;
            if (idx == DW) begin
              if (q0.size() < FD) q0.push_back('{cur_ch, word});
              else d0 = 1'b1;
              if (!cur_ch) begin
                if (q1.size() < FD) q1.push_back('{cur_ch, word});
                else d1 = 1'b1;
              end
            end
          end
          if (fall) begin
            if (ws0 != pws) begin
              if (last_tog >= 0) chk("ws_interval", cyc - last_tog, 2 * CD * (DW + 1));
              last_tog = cyc;
              idx = 0; cur_ch = ws0; word = next_word();
            end else begin
              idx++;
            end
          end
        end
        m_ovf0 = (m_ovf0 && !a_clr) || d0;
        m_ovf1 = (m_ovf1 && !a_clr) || d1;
      end
      psck = sck0;
      pws  = ws0;
      chk("dut0_valid", v0, int'(q0.size() != 0));
      if (q0.size() != 0) begin
        chk("dut0_data", so0, q0[0].data);
        chk("dut0_ch", ch0, q0[0].ch);
      end
      chk("dut0_ovf", ovf0, m_ovf0);
      chk("dut1_valid", v1, int'(q1.size() != 0));
      if (q1.size() != 0) begin
        chk("dut1_data", so1, q1[0].data);
        chk("dut1_ch", ch1, 0);
      end
      chk("dut1_ovf", ovf1, m_ovf1);
      chk("sck_match", sck1, sck0);
      adc = (active && idx >= 1 && idx <= DW) ? word[DW-idx] : 1'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; clr = 1'b0;
    step(2);
    chk("rst_sck", sck0, 0);
    chk("rst_ws", ws0, 0);
    chk("rst_sample", so0, 0);
    chk("rst_ch", ch0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int off_cnt;
    checks = 0; failures = 0; cyc = 0; idx = 0; active = 1'b0; cur_ch = 1'b0;
    psck = 1'b0; pws = 1'b0; word = '0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    last_rise = -1; last_tog = -1; adc = 1'b0; off_cnt = 0;

    vecs[0] = '{"idle", 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0};
    vecs[1] = '{"fill_overflow", 1'b1, 1'b0, 1'b0, 185, 1'b1, 1'b1};
    vecs[2] = '{"clear_ovf", 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    vecs[3] = '{"drain", 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0};
    vecs[4] = '{"stop", 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0};

    do_reset();
    foreach (vecs[i]) begin
      en = vecs[i].en; rdy0 = vecs[i].rdy; rdy1 = vecs[i].rdy; clr = vecs[i].clr;
      step(vecs[i].cycles);
      chk({vecs[i].name, "_valid"}, v0, vecs[i].exp_valid);
      chk({vecs[i].name, "_ovf"}, ovf0, vecs[i].exp_ovf);
    end
    clr = 1'b0;

    // Known stereo pair; each sample appears one clk after its last bit.
    do_reset();
    words_q.push_back(8'hA5);
    words_q.push_back(8'h3C);
    en = 1'b1;
    step(34);
    chk("left_before_last", v0, 0);
    step(1);
    chk("left_valid", v0, 1);
    chk("left_data", so0, 8'hA5);
    chk("left_ch", ch0, 0);
    rdy0 = 1'b1; step(1); rdy0 = 1'b0;
    step(34);
    chk("right_before_last", v0, 0);
    step(1);
    chk("right_valid", v0, 1);
    chk("right_data", so0, 8'h3C);
    chk("right_ch", ch0, 1);

    // Full FIFO with a pop in the push cycle keeps four entries and no overflow.
    do_reset();
    en = 1'b1; rdy1 = 1'b1;
    step(178);
    rdy0 = 1'b1; step(1); rdy0 = 1'b0;
    chk("full_pushpop_ovf", ovf0, 0);
    chk("full_pushpop_valid", v0, 1);
    rdy0 = 1'b1; step(4);
    chk("drained_after_4", v0, 0);

    // Enable dropped mid-slot: partial word discarded, next slot clean.
    do_reset();
    en = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    for (int k = 0; k < 100 && idx != 4; k++) step(1);
    chk("reach_bit4", idx, 4);
    en = 1'b0;
    step(3);
    chk("no_partial0", v0, 0);
    chk("no_partial1", v1, 0);
    words_q.push_back(8'h96);
    en = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    for (int k = 0; k < 100 && !v0; k++) step(1);
    chk("restart_valid", v0, 1);
    chk("restart_data", so0, 8'h96);
    chk("restart_ch", ch0, 0);
    chk("restart_data_mono", so1, 8'h96);

    // Random traffic: slow then fast consumers, sporadic clears and enable drops.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if (off_cnt > 0) begin
        en = 1'b0; off_cnt--;
      end else begin
        en = 1'b1;
        if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 20);
      end
      rdy0 = (k < 2000) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 2) == 0);
      rdy1 = (k < 2000) ? ($urandom_range(0, 95) == 0) : ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      step(1);
    end
    en = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; clr = 1'b0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/team_06_i2s_rx_multi.md
TEAM_06_I2S_RX_MULTI -- requirements
Module: team_06_i2s_rx_multi

Interface
REQ-001 Parameter DATA_W, default 16, bits per audio sample (legal range 8..24).
REQ-002 Parameter NUM_CH, default 2, channels captured (legal values 1 or 2).
REQ-003 Parameter CLK_DIV, default 8, clk cycles per sck half-period (legal range >=2).
REQ-004 Parameter FIFO_DEPTH, default 4, sample FIFO entries (power of 2, >=2).
REQ-005 Port clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1, reset: synchronous and active-high.
REQ-007 Port en, input, 1, capture enable.
REQ-008 Port adc_serial_in, input, 1, serial data from the ADC.
REQ-009 Port sck, output, 1, generated bit clock to the ADC.
REQ-010 Port ws, output, 1, word select; 0 = left (ch0), 1 = right (ch1).
REQ-011 Port sample_out, output, DATA_W, FIFO head sample.
REQ-012 Port ch_out, output, 1, channel of the FIFO head sample.
REQ-013 Port sample_valid, output, 1, FIFO non-empty.
REQ-014 Port sample_ready, input, 1, consumer accepts the head sample.
REQ-015 Port overflow, output, 1, sticky flag set when a sample is dropped.
REQ-016 Port clear_ovf, input, 1, clears overflow.

Function
REQ-017 FSM states: IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; a reset or en=0 SHALL clear the divider, bit counter and shift register.
REQ-018 In IDLE, sck and ws SHALL be held at 0.
REQ-019 In RUN, the divider SHALL count 0..CLK_DIV-1 and toggle sck on the cycle it wraps; the sck period SHALL be 2*CLK_DIV clk cycles.
REQ-020 A rise event SHALL be the clk cycle in which registered sck goes 0->1; a fall event SHALL be the cycle in which it goes 1->0.
REQ-021 Slot length SHALL be DATA_W+1 bit clocks; the bit counter SHALL advance on each rise event and wrap from DATA_W to 0.
REQ-022 Bit 0 of each slot is the I2S delay bit and SHALL be ignored; bits 1..DATA_W SHALL be shifted in MSB first on rise events.
REQ-023 ws SHALL toggle on the fall event that follows the rise event in which the counter reaches DATA_W.
REQ-024 On the capture of bit DATA_W, the sample and current ws SHALL be pushed into the FIFO; when NUM_CH=1, ws=1 slots SHALL be clocked through but SHALL NOT be pushed.
REQ-025 The FIFO SHALL be first-word fall-through: sample_valid=!empty, with sample_out and ch_out showing the head; a pop occurs when sample_valid && sample_ready.
REQ-026 Latency: a pushed sample SHALL be visible with sample_valid=1 one clk after the final-bit capture cycle, provided the FIFO was empty.
REQ-027 Push while full without a simultaneous pop: the new sample SHALL be dropped, the FIFO left unchanged, and overflow set.
REQ-028 Push and pop in the same cycle while full SHALL succeed with no overflow; push and pop while empty SHALL leave the FIFO empty only after the pop of a previously valid head (no bypass).
REQ-029 clear_ovf SHALL clear overflow; if an overflow event occurs in the same cycle, overflow SHALL remain 1.
REQ-030 An en deassertion mid-slot SHALL discard the partial sample and retain FIFO contents, and pops SHALL continue in IDLE.

Reset
REQ-031 When rst=1 at a clk edge: state=IDLE, sck=0, ws=0, sample_out=0, ch_out=0, sample_valid=0, overflow=0, and the FIFO pointers and count SHALL be 0.
REQ-032 rst SHALL take priority over en, sample_ready and clear_ovf; a reset mid-slot SHALL discard all data.

Structure
REQ-033 Package team_06_i2s_pkg SHALL hold the state enum typedef and the default values of DATA_W, NUM_CH, CLK_DIV and FIFO_DEPTH.
REQ-034 The FIFO SHALL be a sub-module team_06_sample_fifo, parametrised by width (DATA_W+1) and depth.

Verification (DATA_W=8, CLK_DIV=2, FIFO_DEPTH=4 unless noted)
REQ-035 Reset, then en=1 -> sck period is 4 clk; ws toggles every 9 sck periods; outputs are 0 before en.
REQ-036 ADC drives left 0xA5 and right 0x3C -> FIFO outputs (ch0, 0xA5) then (ch1, 0x3C), each valid 1 clk after its last bit.
REQ-037 sample_ready=0 for 5 slots -> 4 samples are held, the 5th is dropped, overflow=1; clear_ovf pulse -> overflow=0.
REQ-038 FIFO full with sample_ready=1 in the push cycle -> no overflow and the oldest sample is popped.
REQ-039 en dropped at bit 4 of a slot, then re-raised -> no partial sample appears, and the next full slot is captured correctly.
REQ-040 NUM_CH=1 with stereo data -> only ch0 samples appear, with ch_out=0.
